// File: rtl/lcd_frame_sched.sv
// Frame scheduler for a 240x135 ST7789-class LCD: window commands, then RGB565 pixels as MSB-first bytes.
// Optional LCD_FRAME_SCHED_AUTO_REPEAT_EN: start held at the last byte chains straight into a new RAMWR.
module lcd_frame_sched #(
    parameter int unsigned X_OFS = 40,
    parameter int unsigned Y_OFS = 53,
    parameter int unsigned MAX_W = 240,
    parameter int unsigned MAX_H = 135
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  win_x_i,
    input  logic [7:0]  win_y_i,
    input  logic [7:0]  win_w_i,
    input  logic [7:0]  win_h_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o,
    output logic        pix_ready_o,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    output logic [7:0]  pix_x_o,
    output logic [7:0]  pix_y_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_dc_o,
    output logic        tx_last_o,
    input  logic        tx_ready_i
);

    localparam int unsigned CW = 16;
    localparam int unsigned IW = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(10);

    typedef enum logic [2:0] {IDLE, CMD, PIX_WAIT, PIX_HI, PIX_LO} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    win_x_q, win_y_q, win_w_q, win_h_q;
    logic [7:0]    pix_x_q, pix_y_q, pix_lo_q;
    logic          busy_q, frame_done_q, err_q, pix_ready_q;
    logic          tx_valid_q, tx_dc_q, tx_last_q;
    logic [7:0]    tx_data_q;

    logic [CW-1:0] xs_d, xe_d, ys_d, ye_d;
    logic [8:0]    x_end_d, y_end_d;
    logic          win_ok_d, accept_d, col_end_d, last_pix_d;
    logic [IW-1:0] idx_d;
    logic [9:0]    cmd_d;

    // Entry {dc, last, byte} of the 11-byte CASET/RASET/RAMWR sequence
    function automatic logic [9:0] cmd_byte(input logic [IW-1:0] idx,
                                            input logic [CW-1:0] xs, input logic [CW-1:0] xe,
                                            input logic [CW-1:0] ys, input logic [CW-1:0] ye);
        logic [9:0] b;
        case (idx)
            IW'(0):  b = {2'b00, 8'h2A};
            IW'(1):  b = {2'b10, xs[15:8]};
            IW'(2):  b = {2'b10, xs[7:0]};
            IW'(3):  b = {2'b10, xe[15:8]};
            IW'(4):  b = {2'b11, xe[7:0]};
            IW'(5):  b = {2'b00, 8'h2B};
            IW'(6):  b = {2'b10, ys[15:8]};
            IW'(7):  b = {2'b10, ys[7:0]};
            IW'(8):  b = {2'b10, ye[15:8]};
            IW'(9):  b = {2'b11, ye[7:0]};
            default: b = {2'b00, 8'h2C};
        endcase
        return b;
    endfunction

    assign xs_d       = CW'(X_OFS) + CW'(win_x_q);
    assign xe_d       = xs_d + CW'(win_w_q) - CW'(1);
    assign ys_d       = CW'(Y_OFS) + CW'(win_y_q);
    assign ye_d       = ys_d + CW'(win_h_q) - CW'(1);
    assign x_end_d    = 9'(win_x_i) + 9'(win_w_i);
    assign y_end_d    = 9'(win_y_i) + 9'(win_h_i);
    assign win_ok_d   = (win_w_i != 8'd0) && (win_h_i != 8'd0) &&
                        (x_end_d <= 9'(MAX_W)) && (y_end_d <= 9'(MAX_H));
    assign accept_d   = tx_valid_q & tx_ready_i;
    assign col_end_d  = (pix_x_q == win_w_q - 8'd1);
    assign last_pix_d = col_end_d && (pix_y_q == win_h_q - 8'd1);
    assign idx_d      = idx_q + IW'(1);
    assign cmd_d      = cmd_byte(idx_d, xs_d, xe_d, ys_d, ye_d);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_w_q      <= '0;
            win_h_q      <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_lo_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            pix_ready_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_dc_q      <= 1'b0;
            tx_last_q    <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                // A start coinciding with frame_done is deliberately dropped
                IDLE: begin
                    if (start_i && !frame_done_q) begin
                        if (win_ok_d) begin
                            win_x_q    <= win_x_i;
                            win_y_q    <= win_y_i;
                            win_w_q    <= win_w_i;
                            win_h_q    <= win_h_i;
                            busy_q     <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= CMD;
                            tx_valid_q <= 1'b1;
                            tx_dc_q    <= 1'b0;
                            tx_last_q  <= 1'b0;
                            tx_data_q  <= 8'h2A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (accept_d) begin
                        if (idx_q == LAST_IDX) begin
                            tx_valid_q  <= 1'b0;
                            tx_last_q   <= 1'b0;
                            pix_ready_q <= 1'b1;
                            state_q     <= PIX_WAIT;
                        end else begin
                            idx_q                           <= idx_d;
                            {tx_dc_q, tx_last_q, tx_data_q} <= cmd_d;
                        end
                    end
                end
                PIX_WAIT: begin
                    if (pix_valid_i && pix_ready_q) begin
                        pix_lo_q    <= pix_data_i[7:0];
                        pix_ready_q <= 1'b0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= pix_data_i[15:8];
                        tx_dc_q     <= 1'b1;
                        tx_last_q   <= 1'b0;
                        state_q     <= PIX_HI;
                    end
                end
                PIX_HI: begin
                    if (accept_d) begin
                        tx_data_q <= pix_lo_q;
                        tx_last_q <= last_pix_d;
                        state_q   <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (accept_d) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        if (last_pix_d) begin
                            pix_x_q      <= '0;
                            pix_y_q      <= '0;
                            frame_done_q <= 1'b1;
`ifdef LCD_FRAME_SCHED_AUTO_REPEAT_EN
                            if (start_i) begin
                                idx_q      <= LAST_IDX;
                                state_q    <= CMD;
                                tx_valid_q <= 1'b1;
                                tx_dc_q    <= 1'b0;
                                tx_data_q  <= 8'h2C;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
`else
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`endif
                        end else begin
                            if (col_end_d) begin
                                pix_x_q <= '0;
                                pix_y_q <= pix_y_q + 8'd1;
                            end else begin
                                pix_x_q <= pix_x_q + 8'd1;
                            end
                            pix_ready_q <= 1'b1;
                            state_q     <= PIX_WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;
    assign pix_ready_o  = pix_ready_q;
    assign pix_x_o      = pix_x_q;
    assign pix_y_o      = pix_y_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_data_o    = tx_data_q;
    assign tx_dc_o      = tx_dc_q;
    assign tx_last_o    = tx_last_q;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Scoreboard bench for lcd_frame_sched; the pixel source returns {pix_y, pix_x} as pixel data.
module tb_lcd_frame_sched;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  win_x_i = '0, win_y_i = '0, win_w_i = '0, win_h_i = '0;
    logic        busy_o, frame_done_o, err_o, pix_ready_o;
    logic        pix_valid_i = 1'b0;
    logic [15:0] pix_data_i;
    logic [7:0]  pix_x_o, pix_y_o;
    logic        tx_valid_o, tx_dc_o, tx_last_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    int          fd_exp = 0;
    logic [9:0]  exp_q[$];
    logic        rnd_en = 1'b0;
    logic        stall_pend = 1'b0;
    logic [9:0]  stall_val = '0;

    lcd_frame_sched dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .win_x_i(win_x_i), .win_y_i(win_y_i), .win_w_i(win_w_i), .win_h_i(win_h_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o),
        .pix_ready_o(pix_ready_o), .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_dc_o(tx_dc_o),
        .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i)
    );

    always #5 clk_i = ~clk_i;

    assign pix_data_i = {pix_y_o, pix_x_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Byte monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (stall_pend)
                check("tx_hold", 32'({tx_valid_o, tx_dc_o, tx_last_o, tx_data_o}), 32'({1'b1, stall_val}));
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0)
                    check("tx_extra", 32'(exp_q.size()), 32'd1);
                else
                    check("tx_byte", 32'({tx_dc_o, tx_last_o, tx_data_o}), 32'(exp_q.pop_front()));
                acc_cnt++;
            end
            if (pix_ready_o)
                check("pix_excl", 32'(tx_valid_o), 32'd0);
            if (frame_done_o)
                fd_cnt++;
        end
        stall_pend = !reset_i && tx_valid_o && !tx_ready_i;
        stall_val  = {tx_dc_o, tx_last_o, tx_data_o};
    end

    always @(posedge clk_i) begin
        if (rnd_en) begin
            #1;
            tx_ready_i  = 1'($urandom_range(0, 1));
            pix_valid_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_cmd(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h);
        logic [15:0] xs, xe, ys, ye;
        xs = 16'd40 + 16'(x);
        xe = xs + 16'(w) - 16'd1;
        ys = 16'd53 + 16'(y);
        ye = ys + 16'(h) - 16'd1;
        exp_q.push_back({2'b00, 8'h2A});
        exp_q.push_back({2'b10, xs[15:8]});
        exp_q.push_back({2'b10, xs[7:0]});
        exp_q.push_back({2'b10, xe[15:8]});
        exp_q.push_back({2'b11, xe[7:0]});
        exp_q.push_back({2'b00, 8'h2B});
        exp_q.push_back({2'b10, ys[15:8]});
        exp_q.push_back({2'b10, ys[7:0]});
        exp_q.push_back({2'b10, ye[15:8]});
        exp_q.push_back({2'b11, ye[7:0]});
        exp_q.push_back({2'b00, 8'h2C});
    endtask

    task automatic push_pix(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                exp_q.push_back({2'b10, 8'(y)});
                exp_q.push_back({1'b1, 1'(x == w - 1 && y == h - 1), 8'(x)});
            end
    endtask

    task automatic do_start(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h);
        @(posedge clk_i); #1;
        win_x_i = x; win_y_i = y; win_w_i = w; win_h_i = h;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Returns on the rising edge that completes handshake number tgt
    task automatic wait_acc(input int tgt, input int budget, input string tag);
        int n;
        n = 0;
        while (acc_cnt < tgt && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        if (acc_cnt < tgt) check(tag, 32'(acc_cnt), 32'(tgt));
    endtask

    task automatic frame_end_check(input string tag);
        @(negedge clk_i);
        check({tag, "_done"}, 32'({frame_done_o, busy_o}), 32'b10);
        check({tag, "_pxy"}, 32'({pix_x_o, pix_y_o}), 32'd0);
        @(negedge clk_i);
        check({tag, "_pulse"}, 32'(frame_done_o), 32'd0);
    endtask

    logic [7:0] t1_byte [11] = '{8'h2A, 8'h00, 8'h28, 8'h01, 8'h17, 8'h2B, 8'h00, 8'h35, 8'h00, 8'hBB, 8'h2C};
    logic       t1_dc   [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int tgt;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_ctl", 32'({busy_o, frame_done_o, err_o, pix_ready_o, tx_valid_o, tx_last_o, tx_dc_o}), 32'd0);
        check("rst_data", 32'({tx_data_o, pix_x_o, pix_y_o}), 32'd0);

        // Full-panel window, then reset while the fifth pixel is stalled
        tx_ready_i = 1'b1;
        pix_valid_i = 1'b1;
        for (int i = 0; i < 11; i++)
            exp_q.push_back({t1_dc[i], 1'(i == 4 || i == 9), t1_byte[i]});
        for (int x = 0; x < 4; x++) begin
            exp_q.push_back({2'b10, 8'h00});
            exp_q.push_back({2'b10, 8'(x)});
        end
        tgt = acc_cnt + 19;
        do_start(8'd0, 8'd0, 8'd240, 8'd135);
        @(negedge clk_i);
        check("t1_busy", 32'(busy_o), 32'd1);
        wait_acc(tgt, 200, "t1_timeout");
        #1 tx_ready_i = 1'b0;
        for (int n = 0; n < 20 && !tx_valid_o; n++) @(negedge clk_i);
        check("pix5_hi", 32'({tx_valid_o, tx_data_o}), 32'h100);
        @(posedge clk_i); #1 reset_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("midrst", 32'({tx_valid_o, busy_o, pix_ready_o}), 32'd0);
        check("midrst_sb", 32'(exp_q.size()), 32'd0);
        @(posedge clk_i); #1 reset_i = 1'b0;
        tx_ready_i = 1'b1;

        // 2x2 window after reset: restarts at 2A; start in the frame_done cycle is dropped
        push_cmd(8'd0, 8'd0, 8'd2, 8'd2);
        push_pix(2, 2);
        tgt = acc_cnt + 19;
        do_start(8'd0, 8'd0, 8'd2, 8'd2);
        wait_acc(tgt, 200, "t2_timeout");
        #1 start_i = 1'b1;
        @(negedge clk_i);
        check("t2_done", 32'({frame_done_o, busy_o}), 32'b10);
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i);
        check("t2_fdstart", 32'({busy_o, tx_valid_o, err_o, frame_done_o}), 32'd0);
        fd_exp++;

        // Random backpressure on a 3x1 window; start while busy is ignored
        push_cmd(8'd10, 8'd20, 8'd3, 8'd1);
        push_pix(3, 1);
        tgt = acc_cnt + 17;
        rnd_en = 1'b1;
        do_start(8'd10, 8'd20, 8'd3, 8'd1);
        wait_acc(acc_cnt + 4, 500, "t3_pre");
        do_start(8'd0, 8'd0, 8'd0, 8'd1);
        @(negedge clk_i);
        check("t3_busy_start", 32'({err_o, busy_o}), 32'b01);
        wait_acc(tgt, 2000, "t3_timeout");
        frame_end_check("t3");
        rnd_en = 1'b0;
        @(posedge clk_i); #2;
        tx_ready_i = 1'b1;
        pix_valid_i = 1'b1;
        fd_exp++;

        // Rejected windows: zero width, and right edge past the panel
        do_start(8'd5, 8'd5, 8'd0, 8'd4);
        @(negedge clk_i);
        check("err_w0", 32'({err_o, busy_o, tx_valid_o}), 32'b100);
        @(negedge clk_i);
        check("err_pulse", 32'(err_o), 32'd0);
        do_start(8'd200, 8'd0, 8'd41, 8'd1);
        @(negedge clk_i);
        check("err_xovf", 32'({err_o, busy_o, tx_valid_o}), 32'b100);

        // Bottom-right corner pixel: largest legal start coordinates
        push_cmd(8'd239, 8'd134, 8'd1, 8'd1);
        push_pix(1, 1);
        tgt = acc_cnt + 13;
        do_start(8'd239, 8'd134, 8'd1, 8'd1);
        wait_acc(tgt, 200, "t4_timeout");
        frame_end_check("t4");
        fd_exp++;

`ifdef LCD_FRAME_SCHED_AUTO_REPEAT_EN
        push_cmd(8'd0, 8'd0, 8'd1, 8'd1);
        push_pix(1, 1);
        exp_q.push_back({2'b00, 8'h2C});
        push_pix(1, 1);
        tgt = acc_cnt + 13;
        @(posedge clk_i); #1;
        win_x_i = 8'd0; win_y_i = 8'd0; win_w_i = 8'd1; win_h_i = 8'd1;
        start_i = 1'b1;
        wait_acc(tgt, 200, "ar_first");
        #1 start_i = 1'b0;
        @(negedge clk_i);
        check("ar_chain", 32'({frame_done_o, busy_o, tx_valid_o, tx_data_o}), 32'h72C);
        wait_acc(tgt + 3, 200, "ar_second");
        frame_end_check("ar");
        fd_exp += 2;
`endif

        repeat (3) @(posedge clk_i);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("fd_count", 32'(fd_cnt), 32'(fd_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
